ps2_key_tracker: RTL and testbench

- Parametrised key-state tracker between PS2_Interface and game logic (vga_controller paddle inputs).
- Decodes raw PS/2 Set-2 scan-code bytes, including E0 extended and F0 break prefixes, into per-key held levels and one-cycle press/release pulses.
- Supports several keys held at once, e.g. both players moving paddles simultaneously.
- Replaces single-byte ASCII equality mapping, which allows only one active key at a time.

---
 rtl/ps2_key_tracker.sv | 129 ++++++++++++
 tb/tb_ps2_key_tracker.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_tracker.sv
// rtl/ps2_key_tracker.sv - PS/2 Set-2 scan-code decoder tracking held state of several keys
module ps2_key_tracker #(
    parameter int                      NUM_KEYS       = 4,
    parameter logic [NUM_KEYS*8-1:0]   KEY_CODES      = {8'h4B, 8'h44, 8'h1B, 8'h1D},
    parameter logic [NUM_KEYS-1:0]     KEY_EXT        = '0,
    parameter int                      TIMEOUT_CYCLES = 100000
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic [7:0]          ps2_key_data,
    input  logic                ps2_key_pressed,
    input  logic                clear_all,
    output logic [NUM_KEYS-1:0] key_held,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic                any_held,
    output logic                seq_error
);

    localparam int            CW           = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        GOT_E0,
        GOT_F0,
        GOT_E0F0
    } state_t;

    state_t              state;
    logic [CW-1:0]       tmo_cnt;
    logic [NUM_KEYS-1:0] code_hit;
    logic [NUM_KEYS-1:0] hit_std;
    logic [NUM_KEYS-1:0] hit_ext;
    logic                is_e0;
    logic                is_f0;

    // Compare the incoming byte against every table entry; ext flag splits the hits
    always_comb begin
        code_hit = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            code_hit[i] = (ps2_key_data == KEY_CODES[8*i +: 8]);
        end
        hit_std = code_hit & ~KEY_EXT;
        hit_ext = code_hit & KEY_EXT;
        is_e0   = (ps2_key_data == 8'hE0);
        is_f0   = (ps2_key_data == 8'hF0);
    end

    // Prefix FSM, timeout counter, held levels and registered pulses
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            tmo_cnt     <= '0;
            key_held    <= '0;
            key_press   <= '0;
            key_release <= '0;
            seq_error   <= 1'b0;
        end else begin
            key_press   <= '0;
            key_release <= '0;
            seq_error   <= 1'b0;
            if (clear_all) begin
                // Silent wipe: no release pulses and any coincident byte is dropped
                state    <= IDLE;
                tmo_cnt  <= '0;
                key_held <= '0;
            end else if (ps2_key_pressed) begin
                tmo_cnt <= '0;
                case (state)
                    IDLE: begin
                        if (is_e0) begin
                            state <= GOT_E0;
                        end else if (is_f0) begin
                            state <= GOT_F0;
                        end else begin
                            key_press <= hit_std & ~key_held;
                            key_held  <= key_held | hit_std;
                        end
                    end
                    GOT_E0: begin
                        if (is_f0) begin
                            state <= GOT_E0F0;
                        end else if (!is_e0) begin
                            key_press <= hit_ext & ~key_held;
                            key_held  <= key_held | hit_ext;
                            state     <= IDLE;
                        end
                    end
                    GOT_F0: begin
                        state <= IDLE;
                        if (is_e0 || is_f0) begin
                            seq_error <= 1'b1;
                        end else begin
                            key_release <= hit_std & key_held;
                            key_held    <= key_held & ~hit_std;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        if (is_e0 || is_f0) begin
                            seq_error <= 1'b1;
                        end else begin
                            key_release <= hit_ext & key_held;
                            key_held    <= key_held & ~hit_ext;
                        end
                    end
                endcase
            end else if (state != IDLE) begin
                // A stalled prefix is abandoned so a lost byte cannot wedge the decoder
                if (tmo_cnt == TIMEOUT_LAST) begin
                    state     <= IDLE;
                    tmo_cnt   <= '0;
                    seq_error <= 1'b1;
                end else begin
                    tmo_cnt <= tmo_cnt + CW'(1);
                end
            end else begin
                tmo_cnt <= '0;
            end
        end
    end

    // Summary level straight from the held register
    always_comb begin
        any_held = |key_held;
    end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// tb/tb_ps2_key_tracker.sv - self-checking bench for ps2_key_tracker
module tb_ps2_key_tracker;

    localparam int              NK    = 6;
    localparam int              TMO   = 40;
    localparam logic [NK*8-1:0] CODES = {8'h1B, 8'h75, 8'h4B, 8'h44, 8'h1B, 8'h1D};
    localparam logic [NK-1:0]   EXTS  = 6'b010000;

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic [7:0]    ps2_key_data = 8'h00;
    logic          ps2_key_pressed = 1'b0;
    logic          clear_all = 1'b0;
    logic [NK-1:0] key_held;
    logic [NK-1:0] key_press;
    logic [NK-1:0] key_release;
    logic          any_held;
    logic          seq_error;

    ps2_key_tracker #(
        .NUM_KEYS       (NK),
        .KEY_CODES      (CODES),
        .KEY_EXT        (EXTS),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock           (clock),
        .resetn          (resetn),
        .ps2_key_data    (ps2_key_data),
        .ps2_key_pressed (ps2_key_pressed),
        .clear_all       (clear_all),
        .key_held        (key_held),
        .key_press       (key_press),
        .key_release     (key_release),
        .any_held        (any_held),
        .seq_error       (seq_error)
    );

    always #5 clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    // Reference model: pending prefix bytes as a queue, keys as a bit array
    logic [7:0]    pend[$];
    int            idle_cnt = 0;
    logic [NK-1:0] m_held = '0;
    logic [NK-1:0] m_press = '0;
    logic [NK-1:0] m_rel = '0;
    logic          m_err = 1'b0;

    logic [NK-1:0] exp_held = '0;
    logic [NK-1:0] exp_press = '0;
    logic [NK-1:0] exp_rel = '0;
    logic          exp_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_step(input logic st, input logic [7:0] d, input logic clr);
        bit has_e0;
        bit has_f0;
        m_press = '0;
        m_rel   = '0;
        m_err   = 1'b0;
        if (clr) begin
            m_held = '0;
            pend.delete();
            idle_cnt = 0;
        end else if (st) begin
            idle_cnt = 0;
            has_e0 = 0;
            has_f0 = 0;
            foreach (pend[j]) begin
                if (pend[j] == 8'hE0) has_e0 = 1;
                if (pend[j] == 8'hF0) has_f0 = 1;
            end
            if (d == 8'hE0) begin
                if (pend.size() == 0) pend.push_back(d);
                else if (has_f0) begin m_err = 1'b1; pend.delete(); end
            end else if (d == 8'hF0) begin
                if (has_f0) begin m_err = 1'b1; pend.delete(); end
                else pend.push_back(d);
            end else begin
                for (int k = 0; k < NK; k++) begin
                    if (d == CODES[8*k +: 8] && has_e0 == EXTS[k]) begin
                        if (has_f0) begin
                            if (m_held[k]) begin m_rel[k] = 1'b1; m_held[k] = 1'b0; end
                        end else begin
                            if (!m_held[k]) begin m_press[k] = 1'b1; m_held[k] = 1'b1; end
                        end
                    end
                end
                pend.delete();
            end
        end else if (pend.size() != 0) begin
            idle_cnt++;
            if (idle_cnt == TMO) begin
                m_err = 1'b1;
                pend.delete();
                idle_cnt = 0;
            end
        end
    endtask

    task automatic cyc(input logic st, input logic [7:0] d, input logic clr);
        ps2_key_pressed = st;
        ps2_key_data    = d;
        clear_all       = clr;
        model_step(st, d, clr);
        @(posedge clock);
        exp_held  = m_held;
        exp_press = m_press;
        exp_rel   = m_rel;
        exp_err   = m_err;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0);
    endtask

    task automatic apply_reset(input int n);
        ps2_key_pressed = 1'b0;
        clear_all       = 1'b0;
        resetn          = 1'b0;
        pend.delete();
        idle_cnt  = 0;
        m_held    = '0;
        m_press   = '0;
        m_rel     = '0;
        m_err     = 1'b0;
        exp_held  = '0;
        exp_press = '0;
        exp_rel   = '0;
        exp_err   = 1'b0;
        repeat (n) @(posedge clock);
        #1;
        resetn = 1'b1;
    endtask

    function automatic logic [7:0] pick_byte();
        case ($urandom_range(0, 9))
            0, 1:    return 8'hE0;
            2, 3:    return 8'hF0;
            4:       return 8'h1D;
            5:       return 8'h1B;
            6:       return 8'h44;
            7:       return 8'h4B;
            8:       return 8'h75;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    // Every cycle: DUT outputs against the model's expectations
    always @(negedge clock) begin
        if (chk_en) begin
            chk("key_held", 32'(key_held), 32'(exp_held));
            chk("key_press", 32'(key_press), 32'(exp_press));
            chk("key_release", 32'(key_release), 32'(exp_rel));
            chk("any_held", 32'(any_held), 32'(|exp_held));
            chk("seq_error", 32'(seq_error), 32'(exp_err));
        end
    end

    initial begin
        apply_reset(3);
        chk_en = 1'b1;
        chk("lit_reset_held", 32'(key_held), 32'h0);
        chk("lit_reset_any", 32'(any_held), 32'h0);

        // Two keys down at once
        cyc(1'b1, 8'h1D, 1'b0);
        chk("lit_w_press", 32'(key_press), 32'h01);
        idle(9);
        cyc(1'b1, 8'h4B, 1'b0);
        chk("lit_l_press", 32'(key_press), 32'h08);
        chk("lit_wl_held", 32'(key_held), 32'h09);
        chk("lit_wl_any", 32'(any_held), 32'h1);

        // Typematic repeat then break of W
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 8'h1D, 1'b0);
            chk("lit_repeat_nopress", 32'(key_press), 32'h00);
            idle(2);
        end
        cyc(1'b1, 8'hF0, 1'b0);
        cyc(1'b1, 8'h1D, 1'b0);
        chk("lit_w_release", 32'(key_release), 32'h01);
        chk("lit_after_w_break", 32'(key_held), 32'h08);
        idle(1);
        chk("lit_release_one_cycle", 32'(key_release), 32'h00);

        // Extended-only key 4 (code 75)
        cyc(1'b1, 8'h75, 1'b0);
        chk("lit_ext_plain_ignored", 32'(key_held), 32'h08);
        cyc(1'b1, 8'hE0, 1'b0);
        cyc(1'b1, 8'h75, 1'b0);
        chk("lit_ext_press", 32'(key_press), 32'h10);
        cyc(1'b1, 8'hF0, 1'b0);
        cyc(1'b1, 8'h75, 1'b0);
        chk("lit_ext_plain_break_ignored", 32'(key_held), 32'h18);
        cyc(1'b1, 8'hE0, 1'b0);
        cyc(1'b1, 8'hE0, 1'b0);
        chk("lit_e0_e0_no_error", 32'(seq_error), 32'h0);
        cyc(1'b1, 8'hF0, 1'b0);
        cyc(1'b1, 8'h75, 1'b0);
        chk("lit_ext_release", 32'(key_release), 32'h10);

        // Timeout after a lone F0
        cyc(1'b1, 8'hF0, 1'b0);
        idle(TMO - 1);
        chk("lit_no_early_timeout", 32'(seq_error), 32'h0);
        idle(1);
        chk("lit_timeout_error", 32'(seq_error), 32'h1);
        idle(1);
        chk("lit_timeout_one_pulse", 32'(seq_error), 32'h0);
        cyc(1'b1, 8'h1B, 1'b0);
        chk("lit_make_after_timeout", 32'(key_press), 32'h22);

        // Malformed F0 E0
        cyc(1'b1, 8'hF0, 1'b0);
        cyc(1'b1, 8'hE0, 1'b0);
        chk("lit_f0e0_error", 32'(seq_error), 32'h1);
        cyc(1'b1, 8'h44, 1'b0);
        chk("lit_o_press", 32'(key_press), 32'h04);

        // clear_all with a coincident strobe
        cyc(1'b1, 8'h1D, 1'b0);
        cyc(1'b1, 8'h1B, 1'b1);
        chk("lit_clear_held", 32'(key_held), 32'h00);
        chk("lit_clear_no_release", 32'(key_release), 32'h00);
        chk("lit_clear_no_press", 32'(key_press), 32'h00);

        // Reset in the middle of a break sequence
        cyc(1'b1, 8'h1D, 1'b0);
        cyc(1'b1, 8'hF0, 1'b0);
        apply_reset(2);
        cyc(1'b1, 8'h1D, 1'b0);
        chk("lit_make_after_reset", 32'(key_press), 32'h01);

        // Randomized traffic
        for (int n = 0; n < 2500; n++) begin
            int r;
            r = int'($urandom_range(0, 199));
            if (r < 4) begin
                cyc(1'($urandom_range(0, 1)), pick_byte(), 1'b1);
            end else if (r == 4) begin
                apply_reset(1);
            end else if (r < 10) begin
                idle(int'($urandom_range(TMO - 3, TMO + 3)));
            end else if (r < 110) begin
                cyc(1'b1, pick_byte(), 1'b0);
            end else begin
                idle(int'($urandom_range(1, 3)));
            end
        end
        idle(2);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
